// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO registers: radix-2 shift-add multiply,
// restoring divide, sign fix-up in a final cycle, plus direct MTHI/MTLO writes.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic             is_div_reg;
  logic             neg_hi_reg;
  logic             neg_lo_reg;
  logic             dbz_pending_reg;
  logic [WIDTH-1:0] operand_reg;
  logic [WIDTH-1:0] work_hi_reg;
  logic [WIDTH-1:0] work_lo_reg;

  logic               is_signed_op;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   step_hi_next;
  logic [WIDTH-1:0]   step_lo_next;
  logic [2*WIDTH-1:0] prod_raw;
  logic [WIDTH-1:0]   fix_hi_next;
  logic [WIDTH-1:0]   fix_lo_next;

  always_comb begin
    is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_abs = (is_signed_op && a[WIDTH-1]) ? -a : a;
    b_abs = (is_signed_op && b[WIDTH-1]) ? -b : b;

    // Multiply: work_hi:work_lo is the partial product, multiplier bits shift out of work_lo.
    mul_sum = {1'b0, work_hi_reg} + {1'b0, (work_lo_reg[0] ? operand_reg : {WIDTH{1'b0}})};
    // Divide: work_hi is the remainder, dividend bits shift out of work_lo as quotient bits enter.
    div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand_reg};

    step_hi_next = mul_sum[WIDTH:1];
    step_lo_next = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
    if (is_div_reg) begin
      step_hi_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo_next = {work_lo_reg[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    prod_raw = neg_lo_reg ? -{work_hi_reg, work_lo_reg} : {work_hi_reg, work_lo_reg};
    fix_hi_next = prod_raw[2*WIDTH-1:WIDTH];
    fix_lo_next = prod_raw[WIDTH-1:0];
    if (is_div_reg) begin
      fix_hi_next = neg_hi_reg ? -work_hi_reg : work_hi_reg;
      fix_lo_next = neg_lo_reg ? -work_lo_reg : work_lo_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      is_div_reg      <= 1'b0;
      neg_hi_reg      <= 1'b0;
      neg_lo_reg      <= 1'b0;
      dbz_pending_reg <= 1'b0;
      operand_reg     <= '0;
      work_hi_reg     <= '0;
      work_lo_reg     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      div_by_zero     <= 1'b0;
      hi              <= '0;
      lo              <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              count_reg   <= '0;
              is_div_reg  <= op[1];
              if (op[1] && (b == '0)) begin
                // Divide by zero bypasses the iterations; FIX writes these values verbatim.
                dbz_pending_reg <= 1'b1;
                neg_hi_reg      <= 1'b0;
                neg_lo_reg      <= 1'b0;
                work_hi_reg     <= a;
                work_lo_reg     <= '1;
                state_reg       <= FIX;
              end else begin
                dbz_pending_reg <= 1'b0;
                neg_hi_reg      <= is_signed_op && a[WIDTH-1];
                neg_lo_reg      <= is_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                operand_reg     <= op[1] ? b_abs : a_abs;
                work_hi_reg     <= '0;
                work_lo_reg     <= op[1] ? a_abs : b_abs;
                state_reg       <= RUN;
              end
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          work_hi_reg <= step_hi_next;
          work_lo_reg <= step_lo_next;
          count_reg   <= count_reg + 1'b1;
          if (count_reg == LAST_STEP) state_reg <= FIX;
        end
        FIX: begin
          hi          <= fix_hi_next;
          lo          <= fix_lo_next;
          div_by_zero <= dbz_pending_reg;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, hand sequences for the multi-cycle
// corner cases, and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_in), .a(a_in), .b(b_in),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_hi  = '0;
  logic [W-1:0] m_lo  = '0;
  logic         m_dbz = 1'b0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural meaning of each op.
  task automatic model_apply(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint          p, q, r;
    logic [63:0]     pu;
    case (o)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; m_dbz = 1'b0; end
      3'd1: begin pu = {32'b0, a} * {32'b0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; m_dbz = 1'b0; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          m_hi = a; m_lo = '1; m_dbz = 1'b1;
        end else if (o == 3'd2) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0]; m_dbz = 1'b0;
        end else begin
          m_lo = a / b; m_hi = a % b; m_dbz = 1'b0;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Drive start for one edge, then scramble the inputs so only latched copies can matter.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op_in = o; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; op_in = 3'($urandom); a_in = $urandom; b_in = $urandom;
  endtask

  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0; busy_cnt = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_and_check(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                               input logic e_dbz, input string tag);
    int cyc, bc, exp_lat;
    issue(o, a, b);
    if (o < 3'd4) begin
      exp_lat = ((o[1]) && (b == 0)) ? 1 : W + 1;
      wait_done(cyc, bc);
      check({tag, " latency"}, cyc, exp_lat);
      check({tag, " busy_cycles"}, bc, exp_lat);
      check({tag, " busy_at_done"}, busy, 1'b0);
    end else begin
      check({tag, " done"}, done, 1'b0);
      check({tag, " busy"}, busy, 1'b0);
    end
    check({tag, " hi"}, hi, e_hi);
    check({tag, " lo"}, lo, e_lo);
    check({tag, " dbz"}, div_by_zero, e_dbz);
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b", tag, o, a, b, hi, lo, div_by_zero);
  endtask

  initial begin
    int cyc, bc;
    time t0, t1;
    logic [W-1:0] prev_hi, prev_lo, ra, rb;
    logic [2:0] rop;
    bit done_seen;

    vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, 1'b0};
    vecs[1]  = '{3'd0, 32'hFFFF_FFF9, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{3'd3, 32'd100,       32'h0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{3'd4, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{3'd5, 32'h1234_5678, 32'h0,         32'hDEAD_BEEF, 32'h1234_5678, 1'b1};
    vecs[6]  = '{3'd1, 32'd3,         32'd5,         32'h0,         32'd15,        1'b0};
    vecs[7]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vecs[8]  = '{3'd3, 32'd9,         32'd4,         32'd1,         32'd2,         1'b0};
    vecs[9]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{3'd2, 32'hFFFF_FFFD, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{3'd6, 32'd1,         32'd1,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
    vecs[13] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0};
    vecs[14] = '{3'd3, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 1'b0};
    vecs[15] = '{3'd7, 32'd2,         32'd3,         32'hF,         32'h0FFF_FFFF, 1'b0};

    rst_n = 1'b0; start = 1'b0; op_in = '0; a_in = '0; b_in = '0;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset dbz", div_by_zero, 1'b0);
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Rows run back to back: each arithmetic row ends in its done cycle, where the next starts.
    for (int i = 0; i < 16; i++) begin
      model_apply(vecs[i].op, vecs[i].a, vecs[i].b);
      run_and_check(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
                    $sformatf("vec%0d", i));
    end

    // Done-to-done spacing for back-to-back ops.
    model_apply(3'd1, 32'd6, 32'd7);
    run_and_check(3'd1, 32'd6, 32'd7, m_hi, m_lo, m_dbz, "b2b_first");
    t0 = $time;
    model_apply(3'd3, 32'd9, 32'd4);
    run_and_check(3'd3, 32'd9, 32'd4, m_hi, m_lo, m_dbz, "b2b_second");
    t1 = $time;
    check("b2b period", (t1 - t0) / 10, W + 2);

    // Start/MTLO while busy must be ignored; hi/lo hold during the run.
    prev_hi = m_hi; prev_lo = m_lo;
    model_apply(3'd1, 32'd12345, 32'd6789);
    issue(3'd1, 32'd12345, 32'd6789);
    repeat (9) @(negedge clk);
    start = 1'b1; op_in = 3'd5; a_in = 32'd5; b_in = 32'd1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignore busy", busy, 1'b1);
    check("busy_ignore hold_hi", hi, prev_hi);
    check("busy_ignore hold_lo", lo, prev_lo);
    wait_done(cyc, bc);
    check("busy_ignore latency_rest", cyc, W + 1 - 10);
    check("busy_ignore hi", hi, m_hi);
    check("busy_ignore lo", lo, m_lo);
    $display("busy_ignore MULTU 12345*6789 -> hi=%h lo=%h", hi, lo);

    // Reset in the middle of an operation.
    @(negedge clk);
    issue(3'd1, 32'hFFFF_0000, 32'h1234);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 1'b0);
    check("midreset hi", hi, '0);
    check("midreset lo", lo, '0);
    check("midreset done", done, 1'b0);
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    done_seen = 1'b0;
    repeat (2) begin @(negedge clk); if (done) done_seen = 1'b1; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done || busy) done_seen = 1'b1; end
    check("midreset no_done", done_seen, 1'b0);
    $display("midreset hi=%h lo=%h busy=%b", hi, lo, busy);

    // Randomized ops against the model.
    for (int i = 0; i < 60; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 20)) - 32'd10;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      model_apply(rop, ra, rb);
      run_and_check(rop, ra, rb, m_hi, m_lo, m_dbz, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
